// File: rtl/aes_pkg.sv
// Shared widths and FSM encoding for the AES-128 input block loader.
package aes_pkg;

  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;

  // Word-counter value of the last word slot in a block.
  localparam logic [1:0] CNT_LAST = 2'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } loader_state_t;

endpackage

// File: rtl/ShiftRegister32to128.sv
// 32-to-128 shift stage: each shift pushes a word in at the low end, so the
// first word of a block ends up in bits [127:96] after four shifts.
module ShiftRegister32to128
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_in,
  input  logic [WORD_W-1:0]  data_in,
  output logic [BLOCK_W-1:0] data_out
);

  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (shift_in) begin
      data_d = {data_q[BLOCK_W-WORD_W-1:0], data_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/aes_block_loader.sv
// Assembles 32-bit words into 128-bit AES blocks, zero-padding short final
// blocks, and presents them through a one-entry holding register.
module aes_block_loader
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [1:0]         out_pad,
  input  logic               out_ready
);

  // Handshake: a word moves when in_valid & in_ready at a rising edge, a block
  // moves when out_valid & out_ready; ready never looks at its own valid.

  loader_state_t      state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [1:0]         pad_q, pad_d;

  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [1:0]         out_pad_q, out_pad_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;

  logic               in_ready_c;
  logic               accept;
  logic               move;
  logic               shift_en;
  logic [WORD_W-1:0]  shift_word;
  logic [BLOCK_W-1:0] shift_block;

  ShiftRegister32to128 u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_in (shift_en),
    .data_in  (shift_word),
    .data_out (shift_block)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    pad_d      = pad_q;
    in_ready_c = 1'b0;
    move       = 1'b0;
    shift_en   = 1'b0;
    shift_word = in_data;

    case (state_q)
      FILL: begin
        in_ready_c = 1'b1;
      end
      PAD: begin
        shift_en   = 1'b1;
        shift_word = '0;
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // The completed block leaves for the hold, freeing the shift stage
        // for a new word in the very same cycle.
        move = !out_valid_q || out_ready;
        if (move) begin
          in_ready_c = 1'b1;
          state_d    = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    accept = in_valid && in_ready_c;
    if (accept) begin
      shift_en = 1'b1;
      cnt_d    = cnt_q + 2'd1;
      if (cnt_q == CNT_LAST) begin
        state_d = FULL;
        last_d  = in_last;
        pad_d   = 2'd0;
      end else if (in_last) begin
        state_d = PAD;
        last_d  = 1'b1;
        pad_d   = CNT_LAST - cnt_q;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_pad_d   = out_pad_q;
    out_data_d  = out_data_q;
    if (move) begin
      out_valid_d = 1'b1;
      out_last_d  = last_q;
      out_pad_d   = pad_q;
      out_data_d  = shift_block;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= 2'd0;
      last_q      <= 1'b0;
      pad_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pad_q   <= 2'd0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      pad_q       <= pad_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pad_q   <= out_pad_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_pad   = out_pad_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader: word driver, block scoreboard fed by
// hand-computed expected blocks, and a single summary line.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic [1:0]   out_pad;
  logic         out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;
  int valid_cycles = 0;

  // Expected block entries: {last, pad[1:0], data[127:0]}.
  logic [130:0] exp_q[$];

  aes_block_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_pad   (out_pad),
    .out_ready (out_ready)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic push_block(input logic [127:0] d, input logic l, input logic [1:0] p);
    exp_q.push_back({l, p, d});
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted.
  task automatic send_word(input logic [31:0] d, input logic l);
    int t;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    if (!in_ready) stalls++;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every block transfer is compared against the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid) valid_cycles++;
    if (!reset && out_valid && out_ready) begin
      logic [130:0] e;
      check("sb_block_expected", 128'(exp_q.size() > 0), 128'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e[127:0]);
        check("sb_last", 128'(out_last), 128'(e[130]));
        check("sb_pad", 128'(out_pad), 128'(e[129:128]));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_out_last", 128'(out_last), 128'd0);
    check("rst_out_pad", 128'(out_pad), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full block and latency
    push_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 2'd0);
    send_word(32'h00112233, 1'b0);
    send_word(32'h44556677, 1'b0);
    send_word(32'h8899AABB, 1'b0);
    send_word(32'hCCDDEEFF, 1'b0);
    @(negedge clk);
    check("t1_valid_n1", 128'(out_valid), 128'd0);
    @(negedge clk);
    check("t1_valid_n2", 128'(out_valid), 128'd1);
    check("t1_data", out_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    @(negedge clk);
    check("t1_valid_drop", 128'(out_valid), 128'd0);
    idle(1);

    // Two-word message, padded by two words
    push_block(128'h0000000A_0000000B_00000000_00000000, 1'b1, 2'd2);
    send_word(32'h0000000A, 1'b0);
    send_word(32'h0000000B, 1'b1);
    @(negedge clk);
    check("t2_pad_ready1", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("t2_pad_ready2", 128'(in_ready), 128'd0);
    @(negedge clk);
    check("t2_full_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    check("t2_valid", 128'(out_valid), 128'd1);
    idle(2);

    // Continuous 12-word stream
    stalls = 0;
    valid_cycles = 0;
    push_block(128'h30000000_30000001_30000002_30000003, 1'b0, 2'd0);
    push_block(128'h30000004_30000005_30000006_30000007, 1'b0, 2'd0);
    push_block(128'h30000008_30000009_3000000A_3000000B, 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) send_word(32'h30000000 + 32'(i), 1'b0);
    idle(4);
    check("t3_stalls", 128'(stalls), 128'd0);
    check("t3_valid_cycles", 128'(valid_cycles), 128'd3);

    // Backpressure: two blocks pile up, then drain in order
    out_ready = 1'b0;
    push_block(128'h10000000_10000001_10000002_10000003, 1'b0, 2'd0);
    push_block(128'h20000000_20000001_20000002_20000003, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) send_word(32'h10000000 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) send_word(32'h20000000 + 32'(i), 1'b0);
    @(negedge clk);
    check("t4_ready_low", 128'(in_ready), 128'd0);
    check("t4_hold_valid", 128'(out_valid), 128'd1);
    check("t4_hold_data", out_data, 128'h10000000_10000001_10000002_10000003);
    repeat (3) begin
      @(negedge clk);
      check("t4_hold_stable", out_data, 128'h10000000_10000001_10000002_10000003);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_move_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    check("t4_second_valid", 128'(out_valid), 128'd1);
    check("t4_second_data", out_data, 128'h20000000_20000001_20000002_20000003);
    @(negedge clk);
    check("t4_drained", 128'(out_valid), 128'd0);
    idle(1);

    // Reset with a held block and a partial block in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'h50000000 + 32'(i), 1'b0);
    send_word(32'h60000000, 1'b0);
    send_word(32'h60000001, 1'b0);
    check("t5_pre_valid", 128'(out_valid), 128'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 128'(out_valid), 128'd0);
    check("t5_rst_data", out_data, 128'd0);
    check("t5_rst_last", 128'(out_last), 128'd0);
    check("t5_rst_pad", 128'(out_pad), 128'd0);
    check("t5_rst_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    push_block(128'h70000000_70000001_70000002_70000003, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) send_word(32'h70000000 + 32'(i), 1'b0);
    idle(4);

    // Single-word message, padded by three words
    push_block(128'hFFFFFFFF_00000000_00000000_00000000, 1'b1, 2'd3);
    send_word(32'hFFFFFFFF, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("t6_pad_ready", 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    check("t6_full_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    check("t6_valid", 128'(out_valid), 128'd1);
    idle(2);

    // Last word landing in the final slot: no padding
    push_block(128'h80000000_80000001_80000002_80000003, 1'b1, 2'd0);
    send_word(32'h80000000, 1'b0);
    send_word(32'h80000001, 1'b0);
    send_word(32'h80000002, 1'b0);
    send_word(32'h80000003, 1'b1);
    idle(4);

    // Final report
    check("exp_q_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
